keypad_scanner: RTL and testbench

- Parametrised matrix-keypad scanner for ROWS x COLS key arrays.
- Drives one column at a time and samples the row inputs after a settle delay.
- Classifies each full scan frame as no key, one key or multiple keys, and debounces over consecutive frames.
- Emits one-cycle press/release events with a binary key code; intended to feed a UART/display/command front end.

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/keypad_scanner_if.sv | 40 ++++
 rtl/keypad_debounce.sv | 206 ++++++++++++++++++++
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 tb/tb_keypad_scanner.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the matrix-keypad scanner.
//   frame_res_e   : classification of one full scan frame
//   idx_width()   : bits needed to index n items, never less than 1
//   popcount()    : number of set bits in a vector (up to 32 bits)
//   onehot_to_idx : index of the lowest set bit (up to 32 bits)
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } frame_res_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Lowest set bit wins; callers only use the result when exactly one bit is set.
    function automatic int unsigned onehot_to_idx(input logic [31:0] v);
        int unsigned idx;
        idx = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad matrix wires and the key-event outputs.
//   col         : one-hot column drive          (scanner -> matrix)
//   row         : row sense, 1 = contact        (matrix  -> scanner)
//   key_code    : {row_idx, col_idx} of the committed key
//   key_press   : one-cycle pulse, new key committed (or auto-repeat)
//   key_release : one-cycle pulse, committed key released
//   key_down    : level, a committed key is held
//   ghost       : level, last committed frame result was MULTI
// Modports: master = scanner side, slave = consumer/matrix side.
// -----------------------------------------------------------------------------
interface keypad_scanner_if
    import keypad_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) ();

    localparam int KW = idx_width(ROWS) + idx_width(COLS);

    logic [COLS-1:0] col;
    logic [ROWS-1:0] row;
    logic [KW-1:0]   key_code;
    logic            key_press;
    logic            key_release;
    logic            key_down;
    logic            ghost;

    modport master (
        output col, key_code, key_press, key_release, key_down, ghost,
        input  row
    );

    modport slave (
        input  col, key_code, key_press, key_release, key_down, ghost,
        output row
    );

endinterface

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Debounces per-frame scan results and turns commits into key events.
//   clk, rst     : clock, synchronous active-high reset
//   frame_valid  : strobe, frame_res/frame_code describe a finished frame
//   frame_res    : NONE / SINGLE / MULTI
//   frame_code   : key code, meaningful for SINGLE only
//   key_code, key_press, key_release, key_down, ghost : registered events
// Optional build macro KEYPAD_AUTOREPEAT_EN adds REPEAT_DELAY_FRAMES /
// REPEAT_RATE_FRAMES and re-pulses key_press while a key stays committed.
// -----------------------------------------------------------------------------
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int KW                  = 4,
    parameter int DEBOUNCE_FRAMES      = 3
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY_FRAMES  = 32,
    parameter int REPEAT_RATE_FRAMES   = 8
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_valid,
    input  frame_res_e    frame_res,
    input  logic [KW-1:0] frame_code,
    output logic [KW-1:0] key_code,
    output logic          key_press,
    output logic          key_release,
    output logic          key_down,
    output logic          ghost
);

    localparam int            DW         = idx_width(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] STABLE_MAX = DW'(DEBOUNCE_FRAMES);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                          REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int RPW  = idx_width(RMAX + 1);

    logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
    logic           repeating_q, repeating_d;
    logic [RPW-1:0] rep_inc_s;
    logic [RPW-1:0] rep_target_s;
`endif

    frame_res_e    prev_res_q, prev_res_d;
    logic [KW-1:0] prev_code_q, prev_code_d;
    logic [DW-1:0] stable_q, stable_d;
    frame_res_e    commit_res_q, commit_res_d;
    logic [KW-1:0] commit_code_q, commit_code_d;
    logic [KW-1:0] key_code_q, key_code_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          down_q, down_d;
    logic          ghost_q, ghost_d;

    logic [KW-1:0] code_norm_s;
    logic          same_s;
    logic          commit_s;

    // Next-state: stability count, commit decision and event generation.
    always_comb begin
        prev_res_d    = prev_res_q;
        prev_code_d   = prev_code_q;
        stable_d      = stable_q;
        commit_res_d  = commit_res_q;
        commit_code_d = commit_code_q;
        key_code_d    = key_code_q;
        press_d       = 1'b0;
        release_d     = 1'b0;
        down_d        = down_q;
        ghost_d       = ghost_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d     = rep_cnt_q;
        repeating_d   = repeating_q;
        rep_inc_s     = rep_cnt_q + RPW'(1);
        rep_target_s  = repeating_q ? RPW'(REPEAT_RATE_FRAMES) : RPW'(REPEAT_DELAY_FRAMES);
`endif
        // Code only distinguishes SINGLE results; zero it otherwise so the
        // equality tests below compare result and code in one go.
        code_norm_s = (frame_res == RES_SINGLE) ? frame_code : {KW{1'b0}};
        same_s      = (frame_res == prev_res_q) && (code_norm_s == prev_code_q);
        commit_s    = 1'b0;

        if (frame_valid) begin
            prev_res_d  = frame_res;
            prev_code_d = code_norm_s;
            if (!same_s) begin
                stable_d = DW'(1);
            end else if (stable_q == STABLE_MAX) begin
                stable_d = stable_q;
            end else begin
                stable_d = stable_q + DW'(1);
            end
            commit_s = (stable_d == STABLE_MAX) &&
                       ((frame_res != commit_res_q) || (code_norm_s != commit_code_q));

            if (commit_s) begin
                commit_res_d  = frame_res;
                commit_code_d = code_norm_s;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt_d     = {RPW{1'b0}};
                repeating_d   = 1'b0;
`endif
                case (frame_res)
                    RES_NONE: begin
                        ghost_d = 1'b0;
                        if (down_q) begin
                            release_d = 1'b1;
                            down_d    = 1'b0;
                        end else begin
                            down_d    = 1'b0;
                        end
                    end
                    RES_SINGLE: begin
                        ghost_d = 1'b0;
                        if (!down_q) begin
                            press_d    = 1'b1;
                            key_code_d = code_norm_s;
                            down_d     = 1'b1;
                        end else if (key_code_q != code_norm_s) begin
                            // Direct key-to-key change: release old, press new together.
                            release_d  = 1'b1;
                            press_d    = 1'b1;
                            key_code_d = code_norm_s;
                        end else begin
                            // Same key re-emerging from a ghost frame: still held.
                            key_code_d = key_code_q;
                        end
                    end
                    RES_MULTI: begin
                        ghost_d = 1'b1;
                    end
                    default: begin
                        ghost_d = ghost_q;
                    end
                endcase
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                // Counts frames toward the first delay, then toward each rate period.
                if ((commit_res_q == RES_SINGLE) && down_q) begin
                    if (rep_inc_s == rep_target_s) begin
                        press_d     = 1'b1;
                        rep_cnt_d   = {RPW{1'b0}};
                        repeating_d = 1'b1;
                    end else begin
                        rep_cnt_d   = rep_inc_s;
                    end
                end else begin
                    rep_cnt_d   = {RPW{1'b0}};
                    repeating_d = 1'b0;
                end
`else
                press_d = 1'b0;
`endif
            end
        end else begin
            stable_d = stable_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_res_q    <= RES_NONE;
            prev_code_q   <= {KW{1'b0}};
            stable_q      <= {DW{1'b0}};
            commit_res_q  <= RES_NONE;
            commit_code_q <= {KW{1'b0}};
            key_code_q    <= {KW{1'b0}};
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            down_q        <= 1'b0;
            ghost_q       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q     <= {RPW{1'b0}};
            repeating_q   <= 1'b0;
`endif
        end else begin
            prev_res_q    <= prev_res_d;
            prev_code_q   <= prev_code_d;
            stable_q      <= stable_d;
            commit_res_q  <= commit_res_d;
            commit_code_q <= commit_code_d;
            key_code_q    <= key_code_d;
            press_q       <= press_d;
            release_q     <= release_d;
            down_q        <= down_d;
            ghost_q       <= ghost_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q     <= rep_cnt_d;
            repeating_q   <= repeating_d;
`endif
        end
    end

    assign key_code    = key_code_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_down    = down_q;
    assign ghost       = ghost_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// ROWS x COLS matrix keypad scanner. Drives one column at a time for
// SETTLE_CYCLES clocks, samples the rows on the last clock, classifies each
// full frame as NONE / SINGLE / MULTI and hands it to keypad_debounce.
//   clk, rst : clock, synchronous active-high reset
//   bus      : keypad_scanner_if.master (col out, row in, key event outputs)
// Parameters: ROWS, COLS (2..32), SETTLE_CYCLES (>=2), DEBOUNCE_FRAMES (>=1).
// Optional build macro KEYPAD_AUTOREPEAT_EN adds REPEAT_DELAY_FRAMES and
// REPEAT_RATE_FRAMES (auto-repeat of key_press while a key is held).
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS                = 4,
    parameter int COLS                = 4,
    parameter int SETTLE_CYCLES       = 16,
    parameter int DEBOUNCE_FRAMES     = 3
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY_FRAMES = 32,
    parameter int REPEAT_RATE_FRAMES  = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    keypad_scanner_if.master   bus
);

    localparam int            RW          = idx_width(ROWS);
    localparam int            CW          = idx_width(COLS);
    localparam int            KW          = RW + CW;
    localparam int            SW          = idx_width(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(COLS - 1);

    logic            active_q, active_d;
    logic [CW-1:0]   col_idx_q, col_idx_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [COLS-1:0] col_q, col_d;
    logic            hit_q, hit_d;
    logic            multi_q, multi_d;
    logic [KW-1:0]   hit_code_q, hit_code_d;

    int unsigned     row_cnt_s;
    logic [KW-1:0]   sample_code_s;
    logic            sample_s;
    logic            hit_next_s;
    logic            multi_next_s;
    logic [KW-1:0]   code_next_s;
    logic            frame_valid_s;
    frame_res_e      frame_res_s;
    logic [KW-1:0]   frame_code_s;

    // Column sequencing and per-frame hit accumulation.
    always_comb begin
        active_d      = 1'b1;
        col_idx_d     = col_idx_q;
        settle_d      = settle_q;
        col_d         = col_q;
        hit_d         = hit_q;
        multi_d       = multi_q;
        hit_code_d    = hit_code_q;
        frame_valid_s = 1'b0;
        frame_res_s   = RES_NONE;
        frame_code_s  = {KW{1'b0}};

        row_cnt_s     = popcount(32'(bus.row));
        sample_code_s = {RW'(onehot_to_idx(32'(bus.row))), col_idx_q};
        sample_s      = active_q && (settle_q == SETTLE_LAST);

        // A second contact anywhere in the frame, or several rows at once, is MULTI.
        hit_next_s    = hit_q || (row_cnt_s == 32'd1);
        multi_next_s  = multi_q || (row_cnt_s > 32'd1) || (hit_q && (row_cnt_s == 32'd1));
        code_next_s   = (!hit_q && (row_cnt_s == 32'd1)) ? sample_code_s : hit_code_q;

        if (!active_q) begin
            // First clock out of reset: start driving column 0.
            col_d = {{(COLS-1){1'b0}}, 1'b1};
        end else begin
            if (settle_q == SETTLE_LAST) begin
                settle_d  = {SW{1'b0}};
                col_idx_d = (col_idx_q == COL_LAST) ? {CW{1'b0}} : (col_idx_q + CW'(1));
                col_d     = {{(COLS-1){1'b0}}, 1'b1} << col_idx_d;
            end else begin
                settle_d  = settle_q + SW'(1);
            end

            if (sample_s && (col_idx_q == COL_LAST)) begin
                frame_valid_s = 1'b1;
                if (multi_next_s) begin
                    frame_res_s = RES_MULTI;
                end else if (hit_next_s) begin
                    frame_res_s  = RES_SINGLE;
                    frame_code_s = code_next_s;
                end else begin
                    frame_res_s = RES_NONE;
                end
                hit_d      = 1'b0;
                multi_d    = 1'b0;
                hit_code_d = {KW{1'b0}};
            end else if (sample_s) begin
                hit_d      = hit_next_s;
                multi_d    = multi_next_s;
                hit_code_d = code_next_s;
            end else begin
                hit_d      = hit_q;
            end
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            col_idx_q  <= {CW{1'b0}};
            settle_q   <= {SW{1'b0}};
            col_q      <= {COLS{1'b0}};
            hit_q      <= 1'b0;
            multi_q    <= 1'b0;
            hit_code_q <= {KW{1'b0}};
        end else begin
            active_q   <= active_d;
            col_idx_q  <= col_idx_d;
            settle_q   <= settle_d;
            col_q      <= col_d;
            hit_q      <= hit_d;
            multi_q    <= multi_d;
            hit_code_q <= hit_code_d;
        end
    end

    assign bus.col = col_q;

    keypad_debounce #(
        .KW                  (KW),
        .DEBOUNCE_FRAMES     (DEBOUNCE_FRAMES)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY_FRAMES (REPEAT_DELAY_FRAMES),
        .REPEAT_RATE_FRAMES  (REPEAT_RATE_FRAMES)
`endif
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid_s),
        .frame_res   (frame_res_s),
        .frame_code  (frame_code_s),
        .key_code    (bus.key_code),
        .key_press   (bus.key_press),
        .key_release (bus.key_release),
        .key_down    (bus.key_down),
        .ghost       (bus.ghost)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Bench for keypad_scanner (4x4, settle 4, debounce 3 => 16-clock frames).
// A simulated contact matrix drives the rows from the column drive. A frame-
// level reference model (sample list -> contact count -> result history)
// predicts every output each cycle; directed sections pin latencies and codes.
// Build macro KEYPAD_AUTOREPEAT_EN enables the auto-repeat expectations.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int S    = 4;
    localparam int D    = 3;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RD   = 4;
    localparam int RR   = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] contact = 16'd0;   // bit r*COLS+c = contact at row r / column c
    bit          chk_en = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int n_press  = 0;
    int n_rel    = 0;

    keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

    keypad_scanner #(
        .ROWS                (ROWS),
        .COLS                (COLS),
        .SETTLE_CYCLES       (S),
        .DEBOUNCE_FRAMES     (D)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY_FRAMES (RD),
        .REPEAT_RATE_FRAMES  (RR)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif)
    );

    always #5 clk = ~clk;

    // Physical matrix: a row reads 1 when any driven column has a contact on it.
    always_comb begin
        kif.row = 4'd0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (kif.col[c] && contact[r*COLS + c]) kif.row[r] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  e_col, e_code, e_press, e_rel, e_down, e_ghost;
    bit  m_active;
    int  m_k, m_hits, m_code, m_commit, m_rep;
    int  hist[$];

    task automatic model_frame(input int res);   // res: -1 NONE, -2 MULTI, >=0 code
        bit all_same;
        hist.push_back(res);
        if (hist.size() > D) void'(hist.pop_front());
        all_same = (hist.size() == D);
        foreach (hist[i]) if (hist[i] != hist[0]) all_same = 0;
        if (all_same && res != m_commit) begin
            m_commit = res;
            m_rep = 0;
            if (res == -1) begin
                e_ghost = 0;
                if (e_down == 1) begin e_rel = 1; e_down = 0; end
            end else if (res == -2) begin
                e_ghost = 1;
            end else begin
                e_ghost = 0;
                if (e_down == 0) begin e_press = 1; e_code = res; e_down = 1; end
                else if (e_code != res) begin e_rel = 1; e_press = 1; e_code = res; end
            end
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (m_commit >= 0) begin
                m_rep++;
                if (m_rep == RD || (m_rep > RD && ((m_rep - RD) % RR) == 0)) e_press = 1;
            end else begin
                m_rep = 0;
            end
`endif
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_k = 0; m_hits = 0; m_code = 0; m_commit = -1; m_rep = 0;
            hist.delete();
            e_col = 0; e_code = 0; e_press = 0; e_rel = 0; e_down = 0; e_ghost = 0;
        end else begin
            e_press = 0;
            e_rel   = 0;
            if (!m_active) begin
                m_active = 1;
                m_k = 0;
            end else begin
                int c;
                c = (m_k / S) % COLS;
                if (m_k % S == S - 1) begin
                    int pc;
                    pc = 0;
                    for (int r = 0; r < ROWS; r++) begin
                        if (contact[r*COLS + c]) begin
                            if (m_hits == 0 && pc == 0) m_code = r * COLS + c;
                            pc++;
                        end
                    end
                    m_hits += pc;
                    if (c == COLS - 1) begin
                        model_frame((m_hits == 0) ? -1 : (m_hits == 1) ? m_code : -2);
                        m_hits = 0;
                    end
                end
                m_k++;
            end
            e_col = 1 << ((m_k / S) % COLS);
        end
    end

    // Single compare process: all outputs every cycle, sampled mid-period.
    always @(negedge clk) begin
        if (chk_en) begin
            check("col",         kif.col,         e_col);
            check("key_code",    kif.key_code,    e_code);
            check("key_press",   kif.key_press,   e_press);
            check("key_release", kif.key_release, e_rel);
            check("key_down",    kif.key_down,    e_down);
            check("ghost",       kif.ghost,       e_ghost);
            if (kif.key_press)   n_press++;
            if (kif.key_release) n_rel++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_evt(input bit rel, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(rel ? kif.key_release : kif.key_press) && n < 300);
        check(rel ? "release_seen" : "press_seen", rel ? kif.key_release : kif.key_press, 1);
    endtask

    initial begin
        int n, p0, np;
        int pcyc[8];

        // Power-up reset
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;

        // Reset state and idle scanning
        do_reset();
        check("reset_col", kif.col, 0);
        check("reset_down", kif.key_down, 0);
        check("reset_code", kif.key_code, 0);
        @(posedge clk); #1;
        check("first_col", kif.col, 1);
        p0 = n_press + n_rel;
        repeat (160) @(negedge clk);
        check("idle_events", n_press + n_rel - p0, 0);

        // Row1/col2 press and release
        contact = 16'd0;
        do_reset();
        contact[1*COLS + 2] = 1'b1;
        wait_evt(0, n);
        check("press_latency", n, 49);
        check("press_code", kif.key_code, 4'b0110);
        check("press_down", kif.key_down, 1);
        @(negedge clk) contact = 16'd0;
        wait_evt(1, n);
        check("release_latency", n, 48);
        check("release_down", kif.key_down, 0);
        check("release_code_held", kif.key_code, 4'b0110);

        // Bouncing contact: alternating frames never commit
        do_reset();
        p0 = n_press + n_rel;
        for (int f = 0; f < 6; f++) begin
            contact = (f % 2 == 0) ? 16'h0040 : 16'h0000;
            repeat (16) @(negedge clk);
        end
        contact = 16'd0;
        repeat (64) @(negedge clk);
        check("bounce_events", n_press + n_rel - p0, 0);

        // Ghost: row0 and row3 on col1, then row3 alone
        do_reset();
        p0 = n_press;
        contact = 16'd0;
        contact[0*COLS + 1] = 1'b1;
        contact[3*COLS + 1] = 1'b1;
        repeat (49) @(posedge clk);
        #1;
        check("ghost_set", kif.ghost, 1);
        check("ghost_no_press", n_press - p0, 0);
        @(negedge clk) contact[0*COLS + 1] = 1'b0;
        wait_evt(0, n);
        check("ghost_single_code", kif.key_code, 4'b1101);
        check("ghost_cleared", kif.ghost, 0);

        // Direct change 0000 -> 1111
        contact = 16'd0;
        do_reset();
        contact[0] = 1'b1;
        wait_evt(0, n);
        check("k0_code", kif.key_code, 4'b0000);
        @(negedge clk) contact = 16'h8000;
        wait_evt(0, n);
        check("switch_release", kif.key_release, 1);
        check("switch_code", kif.key_code, 4'b1111);
        check("switch_down", kif.key_down, 1);

        // Reset mid-frame while a key is held
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_col", kif.col, 0);
        check("midrst_down", kif.key_down, 0);
        check("midrst_code", kif.key_code, 0);
        check("midrst_release", kif.key_release, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_col0", kif.col, 1);
        check("midrst_no_release", kif.key_release, 0);

        // Held key over 200 cycles: press schedule
        contact = 16'd0;
        do_reset();
        contact[5] = 1'b1;
        np = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (kif.key_press) begin
                if (np < 8) pcyc[np] = i;
                np++;
            end
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        check("rep_count", np, 4);
        check("rep_0", pcyc[0], 48);
        check("rep_1", pcyc[1], 112);
        check("rep_2", pcyc[2], 144);
        check("rep_3", pcyc[3], 176);
`else
        check("hold_count", np, 1);
        check("hold_0", pcyc[0], 48);
`endif

        // Randomized contact patterns, unaligned changes, occasional reset
        for (int s = 0; s < 60; s++) begin
            int kind;
            @(negedge clk);
            kind = $urandom_range(0, 11);
            if (kind == 0) begin
                rst = 1'b1;
                @(negedge clk) rst = 1'b0;
            end else if (kind <= 3) begin
                contact = 16'd0;
            end else if (kind <= 7) begin
                contact = 16'd0;
                contact[$urandom_range(0, 15)] = 1'b1;
            end else if (kind <= 9) begin
                contact = 16'd0;
                contact[$urandom_range(0, 15)] = 1'b1;
                contact[$urandom_range(0, 15)] = 1'b1;
            end else begin
                contact = 16'($urandom);
            end
            repeat ($urandom_range(8, 80)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
